ex_imm_unit: RTL and testbench
==============================

# ex_imm_unit

Execute-stage block for the immediate-class integer instructions: ORI, ANDI, XORI, LUI, ADDI, ADDIU, SLTI and SLTIU. It consumes the decoded operands, write-back information and opcode produced by the ID stage. It registers them in an ID/EX latch, computes the result, and presents it on a combinational forwarding port and on a registered EX/MEM output. It sits between ID and MEM and supports pipeline stall and flush.

## Interface
- No parameters. Widths come from the global defines: DATA_BUS 32, REG_ADDR_BUS 5, INST_OP_BUS 6.
- Reset rst is synchronous and active-high.

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze both pipeline latches
- flush  in  1  replace both latches with a bubble; wins over stall
- id_valid  in  1  ID presents an instruction this cycle
- id_inst_op  in  6  instruction opcode field
- id_operand_1  in  32  rs value, already forwarded
- id_operand_2  in  32  immediate, already zero/sign/hi-extended by ID
- id_write_reg_en  in  1  destination write requested
- id_write_reg_addr  in  5  destination register (rt)
- fwd_write_en  out  1  EX-stage result is writable this cycle, combinational
- fwd_write_addr  out  5  EX-stage destination
- fwd_write_data  out  32  EX-stage result
- mem_valid  out  1  EX/MEM latch holds an instruction
- mem_write_reg_en  out  1  registered write enable
- mem_write_reg_addr  out  5  registered destination
- mem_result  out  32  registered result
- mem_overflow  out  1  registered ADDI overflow flag

## Operation
- **ID/EX latch:** holds valid, op, op1, op2, wen and waddr.
- **Result** (computed from the latch contents):
  - ORI → op1|op2; ANDI → op1&op2; XORI → op1^op2
  - LUI → op2; op1 is ignored
  - ADDI, ADDIU → op1+op2, truncated to 32 bits
  - SLTI → 32'd1 if $signed(op1) < $signed(op2), else 0
  - SLTIU → 32'd1 if op1 < op2 as unsigned 32-bit values, else 0
  - Any other opcode → result 0, write enable forced 0; valid still propagates.
- **Effective write enable** = latch valid & wen & (waddr != 0) & known op & ~overflow_kill.
- **Overflow** on ADDI only: op1[31]==op2[31] and sum[31]!=op1[31]. Handling depends on the Configuration macro.
- **Forwarding port:**
  - fwd_write_* shows the effective write enable, waddr and result of the ID/EX latch.
  - fwd_write_data is 0 when fwd_write_en=0.
- **EX/MEM latch:** captures valid, effective write enable, waddr, result and overflow.

## Timing
- Latency is 2 edges from ID to the mem_* outputs.
  - ID presents at cycle N.
  - The edge ending N loads ID/EX; fwd_* is valid during N+1.
  - The edge ending N+1 loads EX/MEM; mem_* is valid during N+2.
- **stall=1, flush=0:** both latches hold their values. fwd_* and mem_* are unchanged, and id_* is ignored.
- **flush=1:** on that edge both latches clear valid, wen, addr, result and overflow to 0, regardless of stall.
- **rst=1 at an edge:** all latch fields go to 0. After that edge every output is 0, including mem_valid, mem_overflow and fwd_write_en. This applies mid-operation as well; in-flight instructions are discarded.
- **rst and flush together:** reset behaviour applies.
- **Back-to-back instructions:** the block accepts one instruction every cycle with no bubbles required. A dependent instruction in ID reads fwd_* in the same cycle.
- **id_valid=0:** a bubble enters ID/EX, with wen stored as 0.

## Configuration
- Macro: `EX_OVERFLOW_TRAP_EN`.
- **Defined:**
  - ADDI overflow sets overflow_kill, so effective write enable = 0 on both the fwd and mem paths.
  - mem_overflow=1 for that instruction.
  - ADDIU never traps.
- **Undefined:**
  - mem_overflow is constant 0.
  - ADDI behaves exactly as ADDIU and writes the wrapped sum.

## Test plan
- **ORI:** ORI, op1=0x0000F000, op2=0x000000FF, waddr=8 → fwd_write_data=0x0000F0FF at N+1; at N+2 mem_result=0x0000F0FF, mem_write_reg_en=1, mem_write_reg_addr=8.
- **ADDI overflow:** ADDI, op1=0x7FFFFFFF, op2=0x00000001.
  - With macro: mem_overflow=1, mem_write_reg_en=0, mem_result=0x80000000.
  - Without macro: mem_overflow=0, write_en=1.
- **Signed vs unsigned compare:** op1=0x00000005, op2=0xFFFFFFFF → SLTIU gives result 1; SLTI gives result 0.
- **Stall then flush:** LUI with op2=0x12340000 in flight, stall held 3 cycles → mem_* is unchanged and fwd_* is stable. Then flush=1 with stall=1 → next cycle mem_valid=0 and fwd_write_en=0.
- **Write to $0 and unknown opcode:** ADDIU to waddr=0 → result computed, both write enables 0. Opcode 6'b000000 → mem_valid=1, mem_write_reg_en=0, mem_result=0.
- **Reset mid-operation:** rst for 1 cycle while two instructions are in flight → all outputs 0 the following cycle. A new ORI then completes with the 2-edge latency.

Source files
------------

// File: rtl/ex_imm_unit.sv
// rtl/ex_imm_unit.sv - execute stage for immediate-class integer instructions
//
// Purpose: registers decoded ID outputs into an ID/EX latch, computes the
// ORI/ANDI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU result, exposes it combinationally
// on the forwarding port and registers it into the EX/MEM latch.
//
// Configuration macro: EX_OVERFLOW_TRAP_EN
//   defined   : ADDI signed overflow suppresses the write and sets mem_overflow
//   undefined : ADDI wraps like ADDIU, mem_overflow is constant 0
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall, flush           hold both latches / clear both latches (flush wins)
//   id_valid, id_inst_op   instruction present from ID and its opcode
//   id_operand_1/2         rs value and pre-extended immediate
//   id_write_reg_en/addr   destination write request and register
//   fwd_write_en/addr/data EX-stage result for same-cycle forwarding
//   mem_valid              EX/MEM latch holds an instruction
//   mem_write_reg_en/addr  registered effective write enable and destination
//   mem_result             registered result
//   mem_overflow           registered ADDI overflow flag
module ex_imm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [5:0]  id_inst_op,
  input  logic [31:0] id_operand_1,
  input  logic [31:0] id_operand_2,
  input  logic        id_write_reg_en,
  input  logic [4:0]  id_write_reg_addr,
  output logic        fwd_write_en,
  output logic [4:0]  fwd_write_addr,
  output logic [31:0] fwd_write_data,
  output logic        mem_valid,
  output logic        mem_write_reg_en,
  output logic [4:0]  mem_write_reg_addr,
  output logic [31:0] mem_result,
  output logic        mem_overflow
);

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic        r_ex_valid;
  logic [5:0]  r_ex_op;
  logic [31:0] r_ex_op1;
  logic [31:0] r_ex_op2;
  logic        r_ex_wen;
  logic [4:0]  r_ex_waddr;

  logic        r_mem_valid;
  logic        r_mem_wen;
  logic [4:0]  r_mem_waddr;
  logic [31:0] r_mem_result;
  logic        r_mem_overflow;

  logic [31:0] w_sum;
  logic [31:0] w_result;
  logic        w_known_op;
  logic        w_ovf_kill;
  logic        w_wen_eff;

  // ID/EX latch. A bubble (id_valid=0) is stored as all-zero so stale
  // operands never leak into the result or destination fields.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= 6'd0;
      r_ex_op1   <= 32'd0;
      r_ex_op2   <= 32'd0;
      r_ex_wen   <= 1'b0;
      r_ex_waddr <= 5'd0;
    end else if (!stall) begin
      r_ex_valid <= id_valid;
      r_ex_op    <= id_valid ? id_inst_op        : 6'd0;
      r_ex_op1   <= id_valid ? id_operand_1      : 32'd0;
      r_ex_op2   <= id_valid ? id_operand_2      : 32'd0;
      r_ex_wen   <= id_valid & id_write_reg_en;
      r_ex_waddr <= id_valid ? id_write_reg_addr : 5'd0;
    end
  end

  assign w_sum = r_ex_op1 + r_ex_op2;

  always_comb begin
    w_result   = 32'd0;
    w_known_op = 1'b1;
    case (r_ex_op)
      OP_ORI:            w_result = r_ex_op1 | r_ex_op2;
      OP_ANDI:           w_result = r_ex_op1 & r_ex_op2;
      OP_XORI:           w_result = r_ex_op1 ^ r_ex_op2;
      OP_LUI:            w_result = r_ex_op2;
      OP_ADDI, OP_ADDIU: w_result = w_sum;
      OP_SLTI:           w_result = {31'd0, $signed(r_ex_op1) < $signed(r_ex_op2)};
      OP_SLTIU:          w_result = {31'd0, r_ex_op1 < r_ex_op2};
      default: begin
        w_result   = 32'd0;
        w_known_op = 1'b0;
      end
    endcase
  end

`ifdef EX_OVERFLOW_TRAP_EN
  // Signed overflow: operands share a sign and the sum's sign differs.
  assign w_ovf_kill = r_ex_valid && (r_ex_op == OP_ADDI) &&
                      (r_ex_op1[31] == r_ex_op2[31]) && (w_sum[31] != r_ex_op1[31]);
`else
  assign w_ovf_kill = 1'b0;
`endif

  assign w_wen_eff = r_ex_valid & r_ex_wen & (r_ex_waddr != 5'd0) & w_known_op & ~w_ovf_kill;

  assign fwd_write_en   = w_wen_eff;
  assign fwd_write_addr = r_ex_waddr;
  assign fwd_write_data = w_wen_eff ? w_result : 32'd0;

  // EX/MEM latch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_mem_valid    <= 1'b0;
      r_mem_wen      <= 1'b0;
      r_mem_waddr    <= 5'd0;
      r_mem_result   <= 32'd0;
      r_mem_overflow <= 1'b0;
    end else if (!stall) begin
      r_mem_valid    <= r_ex_valid;
      r_mem_wen      <= w_wen_eff;
      r_mem_waddr    <= r_ex_waddr;
      r_mem_result   <= w_result;
      r_mem_overflow <= w_ovf_kill;
    end
  end

  assign mem_valid          = r_mem_valid;
  assign mem_write_reg_en   = r_mem_wen;
  assign mem_write_reg_addr = r_mem_waddr;
  assign mem_result         = r_mem_result;
  assign mem_overflow       = r_mem_overflow;

endmodule

// File: tb/tb_ex_imm_unit.sv
// tb/tb_ex_imm_unit.sv - scoreboard bench for ex_imm_unit
module tb_ex_imm_unit;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_write_reg_en;
  logic [5:0]  id_inst_op;
  logic [31:0] id_operand_1, id_operand_2;
  logic [4:0]  id_write_reg_addr;
  logic        fwd_write_en, mem_valid, mem_write_reg_en, mem_overflow;
  logic [4:0]  fwd_write_addr, mem_write_reg_addr;
  logic [31:0] fwd_write_data, mem_result;

  always #5 clk = ~clk;

  ex_imm_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_inst_op(id_inst_op),
    .id_operand_1(id_operand_1), .id_operand_2(id_operand_2),
    .id_write_reg_en(id_write_reg_en), .id_write_reg_addr(id_write_reg_addr),
    .fwd_write_en(fwd_write_en), .fwd_write_addr(fwd_write_addr),
    .fwd_write_data(fwd_write_data), .mem_valid(mem_valid),
    .mem_write_reg_en(mem_write_reg_en), .mem_write_reg_addr(mem_write_reg_addr),
    .mem_result(mem_result), .mem_overflow(mem_overflow)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        wen;
    logic [4:0]  addr;
    logic        ovf;
    logic        fwen;
    logic [31:0] fdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] wa);
    id_valid          = v;
    id_inst_op        = op;
    id_operand_1      = a;
    id_operand_2      = b;
    id_write_reg_en   = we;
    id_write_reg_addr = wa;
  endtask

  task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa,
                       input logic [31:0] res, input logic wen, input logic ovf,
                       input logic fwen, input logic [31:0] fdata);
    exp_t x;
    drive(1'b1, op, a, b, 1'b1, wa);
    x.name = nm; x.res = res; x.wen = wen; x.addr = wa;
    x.ovf = ovf; x.fwen = fwen; x.fdata = fdata;
    sb.push_back(x);
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_fwd_en"},   {31'd0, fwd_write_en},     32'd0);
    chk({nm, "_fwd_addr"}, {27'd0, fwd_write_addr},   32'd0);
    chk({nm, "_fwd_data"}, fwd_write_data,            32'd0);
    chk({nm, "_mem_valid"},{31'd0, mem_valid},        32'd0);
    chk({nm, "_mem_wen"},  {31'd0, mem_write_reg_en}, 32'd0);
    chk({nm, "_mem_addr"}, {27'd0, mem_write_reg_addr}, 32'd0);
    chk({nm, "_mem_res"},  mem_result,                32'd0);
    chk({nm, "_mem_ovf"},  {31'd0, mem_overflow},     32'd0);
  endtask

  // Monitor: an edge that loaded EX/MEM with a valid instruction presents a
  // new result; the forwarding view sampled the cycle before belongs to it.
  logic        last_load = 1'b0;
  logic        p_fen;
  logic [4:0]  p_fa;
  logic [31:0] p_fd;

  always @(posedge clk) last_load <= !rst && !flush && !stall;

  always @(negedge clk) begin
    if (last_load && mem_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_mem_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_mem_result"}, mem_result,                  e.res);
        chk({e.name, "_mem_wen"},    {31'd0, mem_write_reg_en},   {31'd0, e.wen});
        chk({e.name, "_mem_addr"},   {27'd0, mem_write_reg_addr}, {27'd0, e.addr});
        chk({e.name, "_mem_ovf"},    {31'd0, mem_overflow},       {31'd0, e.ovf});
        chk({e.name, "_fwd_en"},     {31'd0, p_fen},              {31'd0, e.fwen});
        chk({e.name, "_fwd_addr"},   {27'd0, p_fa},               {27'd0, e.addr});
        chk({e.name, "_fwd_data"},   p_fd,                        e.fdata);
      end
    end
    p_fen = fwd_write_en;
    p_fa  = fwd_write_addr;
    p_fd  = fwd_write_data;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Back-to-back directed vectors.
    issue("ori", OP_ORI, 32'h0000F000, 32'h000000FF, 5'd8, 32'h0000F0FF, 1'b1, 1'b0, 1'b1, 32'h0000F0FF);
    @(negedge clk);
`ifdef EX_OVERFLOW_TRAP_EN
    issue("addi_ovf", OP_ADDI, 32'h7FFFFFFF, 32'h00000001, 5'd9, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h0);
`else
    issue("addi_ovf", OP_ADDI, 32'h7FFFFFFF, 32'h00000001, 5'd9, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h80000000);
`endif
    @(negedge clk);
    issue("sltiu", OP_SLTIU, 32'h00000005, 32'hFFFFFFFF, 5'd10, 32'd1, 1'b1, 1'b0, 1'b1, 32'd1);
    @(negedge clk);
    issue("slti",  OP_SLTI,  32'h00000005, 32'hFFFFFFFF, 5'd11, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    issue("addiu_r0", OP_ADDIU, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    issue("bad_op", 6'b000000, 32'd1, 32'd2, 5'd12, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    issue("andi", OP_ANDI, 32'hFF00FF00, 32'h0F0F0F0F, 5'd13, 32'h0F000F00, 1'b1, 1'b0, 1'b1, 32'h0F000F00);
    @(negedge clk);
    issue("xori", OP_XORI, 32'hFFFF0000, 32'h00FFFF00, 5'd14, 32'hFF00FF00, 1'b1, 1'b0, 1'b1, 32'hFF00FF00);
    @(negedge clk);
    issue("addi_neg", OP_ADDI, 32'd5, 32'hFFFFFFFD, 5'd15, 32'd2, 1'b1, 1'b0, 1'b1, 32'd2);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);

    // Stall with LUI in EX/MEM and an ORI in ID/EX, then flush under stall.
    issue("lui", OP_LUI, 32'hDEADBEEF, 32'h12340000, 5'd3, 32'h12340000, 1'b1, 1'b0, 1'b1, 32'h12340000);
    @(negedge clk);
    drive(1'b1, OP_ORI, 32'd1, 32'd2, 1'b1, 5'd4);   // discarded by the flush
    @(negedge clk);
    stall = 1'b1;
    drive(1'b1, OP_XORI, 32'hAAAAAAAA, 32'h55555555, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mem_valid",  {31'd0, mem_valid},          32'd1);
      chk("stall_mem_result", mem_result,                  32'h12340000);
      chk("stall_mem_wen",    {31'd0, mem_write_reg_en},   32'd1);
      chk("stall_mem_addr",   {27'd0, mem_write_reg_addr}, 32'd3);
      chk("stall_fwd_en",     {31'd0, fwd_write_en},       32'd1);
      chk("stall_fwd_addr",   {27'd0, fwd_write_addr},     32'd4);
      chk("stall_fwd_data",   fwd_write_data,              32'd3);
    end
    flush = 1'b1;
    @(negedge clk);
    chk_all_zero("flush");
    flush = 1'b0; stall = 1'b0;
    idle();
    repeat (2) @(negedge clk);

    // Reset with two instructions in flight.
    issue("pre_rst", OP_ORI, 32'h00000100, 32'h00000001, 5'd5, 32'h00000101, 1'b1, 1'b0, 1'b1, 32'h00000101);
    @(negedge clk);
    drive(1'b1, OP_ADDIU, 32'd10, 32'd20, 1'b1, 5'd6);  // discarded by reset
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk_all_zero("mid_rst");
    rst = 1'b0;
    issue("post_rst", OP_ORI, 32'h00000A00, 32'h00000005, 5'd20, 32'h00000A05, 1'b1, 1'b0, 1'b1, 32'h00000A05);
    @(negedge clk);
    idle();
    chk("post_rst_n1_mem_valid", {31'd0, mem_valid},    32'd0);
    chk("post_rst_n1_fwd_en",    {31'd0, fwd_write_en}, 32'd1);
    @(negedge clk);
    chk("post_rst_n2_mem_valid", {31'd0, mem_valid},    32'd1);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
